dma_w_ch_sched: RTL

Channel scheduler for the multi-channel DMA write path. It watches the fill level and end-of-frame status of every channel's input FIFO and picks one channel per bus burst, using round-robin among the channels that are ready. It presents the chosen channel and burst length to the burst engine, and holds the channel select steady while the burst is on the bus. It sits between the per-channel write FIFOs and the Avalon write burst controller, and drives the FIFO pop/data mux select.

---
 rtl/dma_w_ch_sched_pkg.sv | 21 ++
 rtl/dma_w_ch_sched_if.sv | 37 +++
 rtl/dma_w_ch_sched_rr_arb_ptr.sv | 35 +++
 rtl/dma_w_ch_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/dma_w_ch_sched_pkg.sv
// dma_w_pkg: shared types and helpers for the DMA write-path channel scheduler.
//   sched_st_t   : scheduler FSM state encoding (IDLE, OFFER, BURST)
//   chw()        : channel-select width, max(1, clog2(CH))
//   burst_beats(): beats in a full burst, 2**BL
package dma_w_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BURST = 2'd2
  } sched_st_t;

  function automatic int chw(input int ch);
    return (ch <= 2) ? 1 : $clog2(ch);
  endfunction

  function automatic int burst_beats(input int bl);
    return 1 << bl;
  endfunction

endpackage

// File: rtl/dma_w_ch_sched_if.sv
// dma_w_ch_sched_if: burst offer/handshake bundle between the channel
// scheduler (master) and the Avalon write burst engine (slave).
//   sel_val    : burst offer valid              (master -> slave)
//   sel_rdy    : engine accepts the offer       (slave  -> master)
//   sel_ch     : granted channel / FIFO mux sel (master -> slave)
//   sel_len    : beats in offered burst, 1..2**BL
//   sel_eof    : offered burst drains the frame tail
//   burst_done : last beat of accepted burst written (slave -> master)
//   busy       : a burst is offered or in flight
interface dma_w_ch_sched_if
  import dma_w_pkg::*;
#(
  parameter int CH = 2,
  parameter int BL = 3
);

  localparam int CW = chw(CH);

  logic          sel_val;
  logic          sel_rdy;
  logic [CW-1:0] sel_ch;
  logic [BL:0]   sel_len;
  logic          sel_eof;
  logic          burst_done;
  logic          busy;

  modport master (
    output sel_val, sel_ch, sel_len, sel_eof, busy,
    input  sel_rdy, burst_done
  );

  modport slave (
    input  sel_val, sel_ch, sel_len, sel_eof, busy,
    output sel_rdy, burst_done
  );

endinterface

// File: rtl/dma_w_ch_sched_rr_arb_ptr.sv
// rr_arb_ptr: combinational round-robin picker.
//   req : per-channel request vector
//   ptr : highest-priority channel (always < CH)
//   any : at least one request set
//   win : first requesting channel scanning ptr, ptr+1, ... modulo CH
module rr_arb_ptr
  import dma_w_pkg::*;
#(
  parameter  int CH = 2,
  localparam int CW = chw(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [CW-1:0] ptr,
  output logic          any,
  output logic [CW-1:0] win
);

  // Modular scan instead of a barrel rotate so non-power-of-two CH never
  // visits unused channel codes.
  always_comb begin
    int unsigned idx;
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int unsigned k = 0; k < unsigned'(CH); k++) begin
      idx = 32'(ptr) + k;
      if (idx >= unsigned'(CH)) idx = idx - unsigned'(CH);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_w_ch_sched.sv
// dma_w_ch_sched: picks one DMA write channel per bus burst by round-robin
// among channels whose FIFO holds a full burst or an eof-tagged tail, offers
// it to the burst engine and holds the select steady until the burst is done.
//   clk, rst  : clock, asynchronous active-high reset
//   ch_en     : per-channel armed flag
//   dff_cnt   : per-channel FIFO occupancy (FW+1 bits each)
//   eof_pend  : per-channel eof-tagged word present in FIFO
//   bus       : offer/handshake bundle (master side)
module dma_w_ch_sched
  import dma_w_pkg::*;
#(
  parameter int CH = 2,
  parameter int FW = 8,
  parameter int BL = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       ch_en,
  input  logic [CH-1:0][FW:0] dff_cnt,
  input  logic [CH-1:0]       eof_pend,
  dma_w_ch_sched_if.master    bus
);

  localparam int          CW      = chw(CH);
  localparam logic [FW:0] BEATS   = (FW+1)'(burst_beats(BL));
  localparam logic [BL:0] BEATS_L = (BL+1)'(burst_beats(BL));

  sched_st_t     state_q;
  logic [CW-1:0] ptr_q;
  logic [CW-1:0] sel_ch_q;
  logic [BL:0]   sel_len_q;
  logic          sel_eof_q;
  logic          sel_val_q;
  logic          busy_q;

  logic [CH-1:0] req;
  logic          any;
  logic [CW-1:0] win;
  logic [FW:0]   win_cnt;
  logic [BL:0]   win_len;
  logic          win_eof;

  // A channel asks for the bus with a full burst buffered, or with any
  // data when the frame tail is already in the FIFO.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < unsigned'(CH); i++) begin
      req[i] = ch_en[i] &
               ((dff_cnt[i] >= BEATS) | (eof_pend[i] & (dff_cnt[i] != '0)));
    end
  end

  rr_arb_ptr #(.CH(CH)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  always_comb begin
    win_cnt = dff_cnt[win];
    win_len = (win_cnt >= BEATS) ? BEATS_L : win_cnt[BL:0];
    win_eof = eof_pend[win] & (win_cnt <= BEATS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_ch_q  <= '0;
      sel_len_q <= '0;
      sel_eof_q <= 1'b0;
      sel_val_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q   <= OFFER;
            sel_ch_q  <= win;
            sel_len_q <= win_len;
            sel_eof_q <= win_eof;
            sel_val_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        OFFER: begin
          if (bus.sel_rdy) begin
            state_q   <= BURST;
            sel_val_q <= 1'b0;
            ptr_q     <= (sel_ch_q == CW'(CH-1)) ? '0 : sel_ch_q + 1'b1;
          end
        end
        BURST: begin
          if (bus.burst_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          sel_val_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_val = sel_val_q;
  assign bus.sel_ch  = sel_ch_q;
  assign bus.sel_len = sel_len_q;
  assign bus.sel_eof = sel_eof_q;
  assign bus.busy    = busy_q;

endmodule
